// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for the synchronous FIFO: issues reads, absorbs the
// one-cycle read latency and re-presents words on a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic [DATA_WIDTH-1:0] slot_reg [2];
  logic                  head_reg;
  logic                  tail_reg;
  logic [1:0]            count_reg;
  logic                  inflight_reg;
  logic [CNT_WIDTH-1:0]  xfer_count_reg;

  logic                  pop;
  logic [2:0]            committed;

  assign m_valid    = (count_reg != 2'd0);
  assign m_data     = slot_reg[head_reg];
  assign pop        = m_valid && m_ready;
  assign busy       = inflight_reg || (count_reg != 2'd0);
  assign fifo_cs    = en;
  assign xfer_count = xfer_count_reg;

  // Slots already owed to buffered or in-flight words after this cycle's pop;
  // a read is only issued when its word is guaranteed a place on arrival.
  assign committed  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_rd_en = !rst && en && !fifo_empty && (committed < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (inflight_reg) begin
      for (int i = 0; i < 2; i++) begin
        if (tail_reg == 1'(i)) begin
          slot_reg[i] <= fifo_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= 1'b0;
      tail_reg       <= 1'b0;
      count_reg      <= 2'd0;
      inflight_reg   <= 1'b0;
      xfer_count_reg <= '0;
    end else begin
      inflight_reg <= fifo_rd_en;
      if (inflight_reg) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg       <= ~head_reg;
        xfer_count_reg <= xfer_count_reg + 1'b1;
      end
      count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and stream model with a
// per-cycle compare process plus directed literal checks.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] xfer_count;

  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          rd_smp;
  logic          chk_on;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            outstanding;
  int            acc_count;
  logic          last_rd;
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_cs    (fifo_cs),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO with registered read; it shares the reset of the reader.
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      exp_q.delete();
      fifo_data <= '0;
    end else begin
      if (rd_smp) begin
        if (fq.size() > 0) fifo_data <= fq.pop_front();
        else fifo_data <= '0;
      end
      if (wr_req) begin
        fq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Outstanding = reads issued minus beats accepted (words owed to the sink).
  always @(negedge clk) begin
    logic acc;
    rd_smp = fifo_rd_en;
    if (!chk_on || rst) begin
      outstanding = 0;
      acc_count   = 0;
      last_rd     = 1'b0;
      prev_hold   = 1'b0;
      prev_data   = '0;
    end else begin
      acc = m_valid && m_ready;
      chk("m_valid", m_valid, (outstanding - int'(last_rd)) != 0);
      chk("busy", busy, outstanding != 0);
      chk("xfer_count", xfer_count, acc_count % 16);
      chk("fifo_cs", fifo_cs, en);
      chk("rd_rule", fifo_rd_en, en && !fifo_empty && (outstanding - int'(acc)) < 2);
      chk("rd_on_empty", fifo_rd_en && fifo_empty, 0);
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) chk("order_underrun", 1, 0);
        else chk("order", m_data, exp_q[0]);
      end
      if (acc) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        acc_count++;
      end
      outstanding += int'(fifo_rd_en) - int'(acc);
      last_rd   = fifo_rd_en;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      wr_req  = 1'b1;
      wr_data = base + DW'(k);
      step();
    end
    wr_req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int rd_cnt;
    logic [15:0] rd_mask;
    logic [15:0] acc_mask;
    int written;

    rst = 1'b1; en = 1'b0; m_ready = 1'b0; wr_req = 1'b0; wr_data = '0; chk_on = 1'b0;
    step(); step();
    chk_on = 1'b1;
    rst = 1'b0;

    // Reset with 3 words queued in the FIFO.
    load(32'hA0, 3);
    rst = 1'b1; en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_rd_en", fifo_rd_en, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_xfer", xfer_count, 0);

    // Streaming 0x11..0x18 with the sink always ready.
    step();
    en = 1'b0; m_ready = 1'b1;
    load(32'h11, 8);
    en = 1'b1;
    rd_mask = '0; acc_mask = '0; got.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rd_mask[i] = fifo_rd_en;
      acc_mask[i] = m_valid && m_ready;
      if (m_valid && m_ready) got.push_back(m_data);
    end
    chk("stream_rd_mask", rd_mask, 16'h00FF);
    chk("stream_acc_mask", acc_mask, 16'h03FC);
    chk("stream_count", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("stream_data", got[k], 32'h11 + k);
    chk("stream_xfer", xfer_count, 8);
    chk("stream_busy", busy, 0);
    chk("stream_empty", fifo_empty, 1);

    // Back-pressure: only two reads may be issued while the sink stalls.
    step();
    en = 1'b0; m_ready = 1'b0;
    load(32'h11, 8);
    en = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd_cnt += int'(fifo_rd_en);
    end
    chk("bp_reads", rd_cnt, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 32'h11);
    step();
    m_ready = 1'b1;
    acc_mask = '0; got.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc_mask[i] = m_valid && m_ready;
      if (m_valid && m_ready) got.push_back(m_data);
    end
    chk("bp_acc_mask", acc_mask, 16'h00FF);
    for (int k = 0; k < got.size(); k++) chk("bp_data_seq", got[k], 32'h11 + k);
    chk("bp_xfer_wrap", xfer_count, 0);

    // Enable dropped the cycle after the first read.
    step();
    en = 1'b0;
    load(32'h31, 2);
    en = 1'b1;
    step();
    en = 1'b0;
    rd_cnt = 0; got.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_cnt += int'(fifo_rd_en);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    chk("endrop_reads", rd_cnt, 0);
    chk("endrop_count", got.size(), 1);
    if (got.size() > 0) chk("endrop_data", got[0], 32'h31);
    chk("endrop_xfer", xfer_count, 1);
    chk("endrop_busy", busy, 0);
    step();
    en = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    chk("resume_count", got.size(), 1);
    if (got.size() > 0) chk("resume_data", got[0], 32'h32);
    chk("resume_xfer_18", xfer_count, 2);

    // Random ready with 64 words written concurrently.
    written = 0;
    for (int c = 0; c < 3000 && acc_count < 82; c++) begin
      step();
      wr_req  = (written < 64) && ($urandom_range(0, 2) != 0);
      wr_data = $urandom;
      if (wr_req) written++;
      m_ready = ($urandom_range(0, 2) != 0);
    end
    wr_req = 1'b0;
    m_ready = 1'b1;
    chk("random_done", acc_count, 82);
    step(); step(); step();
    @(negedge clk);
    chk("random_busy", busy, 0);
    chk("random_xfer", xfer_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
